// File: rtl/seq_divider.sv
`timescale 1ns/1ps
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per
// clock, with a Start/Busy/Done handshake, divide-by-zero detection and
// results that are held between operations.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  // After every restore the partial remainder is below the divisor, so its
  // top bit is always zero and is not kept; it reappears in w_shift.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_m;
  logic [CW-1:0]    r_cnt;

  logic             r_busy, r_done, r_dbz;
  logic [WIDTH-1:0] r_quo, r_rem;

  logic             w_accept, w_last, w_neg;
  logic [WIDTH:0]   w_shift, w_trial;
  logic [WIDTH-1:0] w_a_step, w_q_step;

  assign w_accept = i_start && (r_state != S_RUN);
  assign w_last   = (r_cnt == CW'(1));
  assign w_shift  = {r_a, r_q[WIDTH-1]};
  assign w_trial  = w_shift - r_m;
  assign w_neg    = w_trial[WIDTH];
  assign w_a_step = w_neg ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_q_step = {r_q[WIDTH-2:0], ~w_neg};

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: divide-by-zero skips RUN and completes immediately
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) w_state_nxt = (i_divisor == '0) ? S_DONE : S_RUN;
        else          w_state_nxt = S_IDLE;
      end
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, one shift/subtract step per RUN cycle, and
  // the result registers that change only on completion
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a   <= '0;
      r_q   <= '0;
      r_m   <= '0;
      r_cnt <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_a   <= '0;
      r_q   <= i_dividend;
      r_m   <= {1'b0, i_divisor};
      r_cnt <= CW'(WIDTH);
      if (i_divisor == '0) begin
        r_quo <= '1;
        r_rem <= i_dividend;
        r_dbz <= 1'b1;
      end
    end else if (r_state == S_RUN) begin
      r_a   <= w_a_step;
      r_q   <= w_q_step;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_quo <= w_q_step;
        r_rem <= w_a_step;
        r_dbz <= 1'b0;
      end
    end
  end

  // Registered handshake flags, aligned with the state they describe;
  // entering DONE always means a fresh result
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_RUN);
      r_done <= (w_state_nxt == S_DONE);
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;
  assign o_quotient    = r_quo;
  assign o_remainder   = r_rem;

endmodule

// File: tb/tb_seq_divider.sv
`timescale 1ns/1ps
// tb_seq_divider: three divider instances (WIDTH 8, 4, 16) checked every
// cycle against a result-level model, plus directed literal expectations.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]       st, bsy, dn, dz, mb, md, mz;
  logic [2:0][15:0] dvd, dvs, quo, rem, mq, mr;

  int n_chk  = 0;
  int n_fail = 0;

  initial begin
    st  = '0;
    dvd = '0;
    dvs = '0;
  end

  for (genvar g = 0; g < 3; g++) begin : gw
    localparam int W = (g == 0) ? 8 : ((g == 1) ? 4 : 16);
    localparam logic [15:0] ONES = 16'((32'd1 << W) - 1);

    wire [W-1:0] w_q, w_r;

    seq_divider #(.WIDTH(W)) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (st[g]),
      .i_dividend   (dvd[g][W-1:0]),
      .i_divisor    (dvs[g][W-1:0]),
      .o_busy       (bsy[g]),
      .o_done       (dn[g]),
      .o_div_by_zero(dz[g]),
      .o_quotient   (w_q),
      .o_remainder  (w_r)
    );
    assign quo[g] = 16'(w_q);
    assign rem[g] = 16'(w_r);

    // Model: an accepted request is busy for W cycles, then the result is
    // simply a/b and a%b; divide-by-zero completes on the next cycle.
    logic        b, d, z;
    logic [15:0] q, r, ca, cb;
    int          left;
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        b <= 0; d <= 0; z <= 0; q <= 0; r <= 0; ca <= 0; cb <= 0; left <= 0;
      end else begin
        d <= 0;
        if (b) begin
          if (left == 1) begin
            b <= 0; d <= 1; q <= ca / cb; r <= ca % cb; z <= 0;
          end
          left <= left - 1;
        end else if (st[g]) begin
          if (dvs[g][W-1:0] == 0) begin
            d <= 1; q <= ONES; r <= 16'(dvd[g][W-1:0]); z <= 1;
          end else begin
            b <= 1; left <= W;
            ca <= 16'(dvd[g][W-1:0]); cb <= 16'(dvs[g][W-1:0]);
          end
        end
      end
    end
    assign mb[g] = b;
    assign md[g] = d;
    assign mz[g] = z;
    assign mq[g] = q;
    assign mr[g] = r;
  end

  task automatic chk(input string nm, input int i, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", nm, i, act, exp);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        chk("busy",  i, 16'(bsy[i]), 16'(mb[i]));
        chk("done",  i, 16'(dn[i]),  16'(md[i]));
        chk("dbz",   i, 16'(dz[i]),  16'(mz[i]));
        chk("quot",  i, quo[i], mq[i]);
        chk("rem",   i, rem[i], mr[i]);
      end
    end
  end

  // Issue one request (called at a negedge); optionally inject a second
  // request with other operands at RUN cycle inj. Returns cycles to Done
  // and number of cycles Busy was seen high.
  task automatic run(input int g, input logic [15:0] a, input logic [15:0] bb,
                     input int inj, output int lat, output int nb);
    dvd[g] = a; dvs[g] = bb; st[g] = 1'b1;
    lat = 0; nb = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) st[g] = 1'b0;
      if (inj > 0 && k == inj) begin st[g] = 1'b1; dvd[g] = 50; dvs[g] = 5; end
      if (inj > 0 && k == inj + 1) st[g] = 1'b0;
      if (bsy[g]) nb++;
      if (dn[g]) begin lat = k; break; end
    end
    if (lat == 0) begin
      n_chk++; n_fail++;
      $display("FAIL timeout[%0d]: no done seen, required within 60 cycles", g);
    end
  endtask

  task automatic res(input string nm, input int g, input int lat, input int elat,
                     input logic [15:0] eq, input logic [15:0] er, input logic ez);
    chk({nm, "_lat"}, g, 16'(lat), 16'(elat));
    chk({nm, "_q"},   g, quo[g], eq);
    chk({nm, "_r"},   g, rem[g], er);
    chk({nm, "_z"},   g, 16'(dz[g]), 16'(ez));
  endtask

  initial begin
    int lat, nb, nd, last;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", i, 16'(bsy[i]), 16'd0);
      chk("rst_done", i, 16'(dn[i]),  16'd0);
      chk("rst_dbz",  i, 16'(dz[i]),  16'd0);
      chk("rst_q",    i, quo[i], 16'd0);
      chk("rst_r",    i, rem[i], 16'd0);
    end
    rst = 1'b0;

    // 200/7 on WIDTH=8
    run(0, 200, 7, 0, lat, nb);
    res("t200_7", 0, lat, 9, 28, 4, 0);
    chk("t200_7_busy_cycles", 0, 16'(nb), 16'd8);
    chk("model_q", 0, mq[0], 16'd28);
    chk("model_r", 0, mr[0], 16'd4);
    @(negedge clk);
    chk("done_pulse", 0, 16'(dn[0]), 16'd0);
    chk("hold_q", 0, quo[0], 16'd28);

    // WIDTH=4: 15/4 then 5/9
    run(1, 15, 4, 0, lat, nb);
    res("t15_4", 1, lat, 5, 3, 3, 0);
    run(1, 5, 9, 0, lat, nb);
    res("t5_9", 1, lat, 5, 0, 5, 0);

    // divide by zero, then 255/1
    @(negedge clk);
    run(0, 255, 0, 0, lat, nb);
    res("t255_0", 0, lat, 1, 255, 255, 1);
    chk("t255_0_busy_cycles", 0, 16'(nb), 16'd0);
    run(0, 255, 1, 0, lat, nb);
    res("t255_1", 0, lat, 9, 255, 0, 0);

    // 100/3 with an ignored 50/5 request mid-run
    @(negedge clk);
    run(0, 100, 3, 3, lat, nb);
    res("t100_3", 0, lat, 9, 33, 1, 0);
    repeat (4) @(negedge clk);
    chk("hold_done", 0, 16'(dn[0]), 16'd0);
    chk("hold_q2", 0, quo[0], 16'd33);
    chk("hold_r2", 0, rem[0], 16'd1);

    // reset mid-run discards the operation
    dvd[0] = 200; dvs[0] = 7; st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 0, 16'(bsy[0]), 16'd0);
    chk("mid_rst_done", 0, 16'(dn[0]),  16'd0);
    chk("mid_rst_dbz",  0, 16'(dz[0]),  16'd0);
    chk("mid_rst_q",    0, quo[0], 16'd0);
    chk("mid_rst_r",    0, rem[0], 16'd0);
    @(negedge clk); rst = 1'b0;
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      if (dn[0]) nd++;
    end
    chk("no_done_after_rst", 0, 16'(nd), 16'd0);
    run(0, 9, 2, 0, lat, nb);
    res("t9_2", 0, lat, 9, 4, 1, 0);

    // WIDTH=16 back-to-back with Start held high
    @(negedge clk);
    dvd[2] = 65535; dvs[2] = 255; st[2] = 1'b1;
    nd = 0; last = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (dn[2]) begin
        nd++;
        chk("b2b_gap", 2, 16'(k - last), 16'd17);
        chk("b2b_q", 2, quo[2], 16'd257);
        chk("b2b_r", 2, rem[2], 16'd0);
        last = k;
        if (nd == 3) begin st[2] = 1'b0; break; end
      end
    end
    st[2] = 1'b0;
    chk("b2b_count", 2, 16'(nd), 16'd3);
    repeat (3) @(negedge clk);
    chk("b2b_idle_busy", 2, 16'(bsy[2]), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
